// File: rtl/tap_mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tap_mem_arb_pkg : shared widths and types for the tap memory arbiter      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package tap_mem_arb_pkg;

  localparam int FLOAT_24_8_W  = 32;
  localparam int TAPS_PER_WORD = 6;
  localparam int TAP_ADDR_W    = 4;
  localparam int TAP_DATA_W    = FLOAT_24_8_W * TAPS_PER_WORD;

  typedef struct packed {
    logic [TAP_ADDR_W-1:0] addr;
    logic [TAP_DATA_W-1:0] data;
  } tap_wr_req_t;

endpackage
`default_nettype wire

// File: rtl/tap_wr_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tap_wr_fifo : sync FIFO of pending tap writes, exposes stored addresses   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tap_wr_fifo
  import tap_mem_arb_pkg::*;
#(
  parameter int ADDR_W = TAP_ADDR_W,
  parameter int DATA_W = TAP_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         entry_vld,
  output logic [DEPTH*ADDR_W-1:0]  entry_addr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign do_push   = push & ~full;
  // Pop is qualified by the registered empty flag, so a push into an empty
  // FIFO cannot be popped in the same cycle.
  assign do_pop    = pop & ~empty;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_addr = addr_q[rd_ptr_q[IDX_W-1:0]];
  assign head_data = data_q[rd_ptr_q[IDX_W-1:0]];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [IDX_W-1:0] offset;
    assign offset       = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
    assign entry_vld[i] = ({1'b0, offset} < count);
    assign entry_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (do_push) begin
      addr_d[wr_ptr_q[IDX_W-1:0]] = push_addr;
      data_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule
`default_nettype wire

// File: rtl/tap_mem_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tap_mem_arb : read-priority arbiter for the single-port tap memory with a |
// | buffered write path. Optional stats counters: TAP_ARB_STATS_EN.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tap_mem_arb
  import tap_mem_arb_pkg::*;
#(
  parameter int ADDR_W        = TAP_ADDR_W,
  parameter int DATA_W        = TAP_DATA_W,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_vld,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  input  logic              wr_req_vld,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_req_rdy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              wr_pending
`ifdef TAP_ARB_STATS_EN
  ,
  output logic [15:0]       stat_rd_grants,
  output logic [15:0]       stat_wr_grants,
  output logic [15:0]       stat_stall_cycles
`endif
);

  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [ADDR_W-1:0]             fifo_head_addr;
  logic [DATA_W-1:0]             fifo_head_data;
  logic [WR_FIFO_DEPTH-1:0]      fifo_entry_vld;
  logic [WR_FIFO_DEPTH*ADDR_W-1:0] fifo_entry_addr;

  logic                run;
  logic                pending;
  logic                push;
  logic                addr_hit;
  logic                hazard;
  logic                force_wr;
  logic                wr_grant;
  logic                rd_grant;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_sat;
  logic                rd_data_vld_q, rd_data_vld_d;

  // Outputs are held low while reset is asserted so nothing leaks out before
  // the registered state is known.
  assign run        = ~reset;
  assign pending    = ~fifo_empty;
  assign wr_req_rdy = run & ~fifo_full;
  assign push       = wr_req_vld & wr_req_rdy;
  assign wr_pending = run & pending;

  tap_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (wr_req_addr),
    .push_data  (wr_req_data),
    .pop        (wr_grant),
    .head_addr  (fifo_head_addr),
    .head_data  (fifo_head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entry_vld  (fifo_entry_vld),
    .entry_addr (fifo_entry_addr)
  );

  // Only stored entries are compared; the write arriving this cycle is not.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < WR_FIFO_DEPTH; i++) begin
      if (fifo_entry_vld[i] && (fifo_entry_addr[i*ADDR_W +: ADDR_W] == rd_req_addr)) begin
        addr_hit = 1'b1;
      end
    end
  end

  assign hazard     = rd_req_vld & addr_hit;
  assign streak_sat = (streak_q == STREAK_W'(MAX_RD_STREAK));
  assign force_wr   = pending & streak_sat;
  assign wr_grant   = run & pending & (~rd_req_vld | hazard | force_wr);
  assign rd_grant   = run & rd_req_vld & ~wr_grant;
  assign rd_req_rdy = rd_grant;

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (wr_grant) begin
      mem_en      = 1'b1;
      mem_we      = 1'b1;
      mem_addr    = fifo_head_addr;
      mem_wr_data = fifo_head_data;
    end else if (rd_grant) begin
      mem_en   = 1'b1;
      mem_addr = rd_req_addr;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (wr_grant || !pending) begin
      streak_d = '0;
    end else if (rd_grant && !streak_sat) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  assign rd_data_vld_d = rd_grant;
  assign rd_data_vld   = rd_data_vld_q;
  assign rd_data       = mem_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q      <= '0;
      rd_data_vld_q <= 1'b0;
    end else begin
      streak_q      <= streak_d;
      rd_data_vld_q <= rd_data_vld_d;
    end
  end

`ifdef TAP_ARB_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_rd_d    = stat_rd_q;
    stat_wr_d    = stat_wr_q;
    stat_stall_d = stat_stall_q;
    if (rd_grant && stat_rd_q != 16'hFFFF) begin
      stat_rd_d = stat_rd_q + 16'd1;
    end
    if (wr_grant && stat_wr_q != 16'hFFFF) begin
      stat_wr_d = stat_wr_q + 16'd1;
    end
    if (rd_req_vld && !rd_req_rdy && stat_stall_q != 16'hFFFF) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_rd_grants    = stat_rd_q;
  assign stat_wr_grants    = stat_wr_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule
`default_nettype wire
